// File: rtl/alu_pipe_elastic_pkg.sv
// Shared types and constants for the elastic ALU result pipeline.
package alu_pipe_elastic_pkg;

    localparam int unsigned DWIDTH_DEF = 32;
    localparam int unsigned TAG_W_DEF  = 4;
    localparam int unsigned STAGES_DEF = 3;

    // ALU operation select.
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_sel_e;

    // Stage payload at the default widths; the flat stage vector uses the same field order.
    typedef struct packed {
        logic [DWIDTH_DEF-1:0] res;
        logic                  zero;
        logic                  neg;
        logic [TAG_W_DEF-1:0]  tag;
    } alu_pipe_payload_t;

    // Width of one flattened stage payload {res, zero, neg, tag}.
    function automatic int unsigned payload_w(input int unsigned dw, input int unsigned tw);
        return dw + tw + 2;
    endfunction

endpackage

// File: rtl/alu_pipe_elastic_if.sv
// Handshake and data bundle of the elastic ALU pipeline (input side, output side, flush).
interface alu_pipe_elastic_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned TAG_W  = 4
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [1:0]        sel_i;
    logic [DWIDTH-1:0] op1_i;
    logic [DWIDTH-1:0] op2_i;
    logic [TAG_W-1:0]  tag_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DWIDTH-1:0] res_o;
    logic              zero_o;
    logic              neg_o;
    logic [TAG_W-1:0]  tag_o;

    // Pipeline side.
    modport slave (
        input  flush_i, in_valid_i, sel_i, op1_i, op2_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, res_o, zero_o, neg_o, tag_o
    );

    // Producer/consumer side.
    modport master (
        output flush_i, in_valid_i, sel_i, op1_i, op2_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, res_o, zero_o, neg_o, tag_o
    );
endinterface

// File: rtl/alu_pipe_elastic_alu.sv
// Combinational ALU: modulo-2^DWIDTH add/sub, bitwise and/or.
module alu
    import alu_pipe_elastic_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic [1:0]        sel_i,
    input  logic [DWIDTH-1:0] op1_i,
    input  logic [DWIDTH-1:0] op2_i,
    output logic [DWIDTH-1:0] res_o
);

    // Operation decode; carry/borrow are dropped by the result width.
    always_comb begin
        res_o = '0;
        case (alu_sel_e'(sel_i))
            ALU_ADD: res_o = op1_i + op2_i;
            ALU_SUB: res_o = op1_i - op2_i;
            ALU_AND: res_o = op1_i & op2_i;
            ALU_OR:  res_o = op1_i | op2_i;
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe_elastic_stage.sv
// One elastic register stage: valid bit plus payload, advancing when adv_i is high.
module alu_pipe_stage #(
    parameter int unsigned PW = 38
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          adv_i,
    input  logic          valid_i,
    input  logic [PW-1:0] data_i,
    output logic          valid_o,
    output logic [PW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [PW-1:0] data_q, data_d;

    // Next state: flush clears valid only; payload loads only with a valid element so it holds when empty.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (adv_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    // Stage registers with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/alu_pipe_elastic.sv
// Elastic ALU result pipeline of STAGES register stages with valid/ready and flush.
// Optional ALU_PIPE_PERF_EN adds handshake and stall counters (perf_ops_o, perf_stall_o).
module alu_pipe_elastic
    import alu_pipe_elastic_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned STAGES = STAGES_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    alu_pipe_elastic_if.slave  bus
`ifdef ALU_PIPE_PERF_EN
    ,
    output logic [31:0]        perf_ops_o,
    output logic [31:0]        perf_stall_o
`endif
);

    localparam int unsigned PW   = payload_w(DWIDTH, TAG_W);
    localparam int unsigned LAST = STAGES - 1;

    logic [DWIDTH-1:0] alu_res_c;
    logic              zero_c;
    logic              neg_c;
    logic [PW-1:0]     head_payload_c;
    logic              head_valid_c;
    logic              in_ready_c;
    logic [STAGES-1:0] adv_c;
    logic [STAGES-1:0] stage_valid;
    logic [PW-1:0]     stage_data [STAGES];

    alu #(.DWIDTH(DWIDTH)) u_alu (
        .sel_i (bus.sel_i),
        .op1_i (bus.op1_i),
        .op2_i (bus.op2_i),
        .res_o (alu_res_c)
    );

    assign zero_c         = (alu_res_c == '0);
    assign neg_c          = alu_res_c[DWIDTH-1];
    assign head_payload_c = {alu_res_c, zero_c, neg_c, bus.tag_i};

    // Advance chain from the output back to the head: a stage moves if empty or its successor moves.
    always_comb begin
        logic chain;
        adv_c       = '0;
        chain       = !stage_valid[LAST] | bus.out_ready_i;
        adv_c[LAST] = chain;
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            chain    = !stage_valid[i] | chain;
            adv_c[i] = chain;
        end
    end

    assign in_ready_c     = adv_c[0] & !bus.flush_i;
    assign head_valid_c   = bus.in_valid_i & in_ready_c;
    assign bus.in_ready_o = in_ready_c;

    // Stage chain: stage 0 captures the ALU result, later stages take their predecessor.
    for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
        if (g == 0) begin : g_head
            alu_pipe_stage #(.PW(PW)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .flush_i (bus.flush_i),
                .adv_i   (adv_c[g]),
                .valid_i (head_valid_c),
                .data_i  (head_payload_c),
                .valid_o (stage_valid[g]),
                .data_o  (stage_data[g])
            );
        end else begin : g_body
            alu_pipe_stage #(.PW(PW)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .flush_i (bus.flush_i),
                .adv_i   (adv_c[g]),
                .valid_i (stage_valid[g-1]),
                .data_i  (stage_data[g-1]),
                .valid_o (stage_valid[g]),
                .data_o  (stage_data[g])
            );
        end
    end

    assign bus.out_valid_o = stage_valid[LAST];
    assign {bus.res_o, bus.zero_o, bus.neg_o, bus.tag_o} = stage_data[LAST];

`ifdef ALU_PIPE_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Counter next state: completed handshakes and stalled-output cycles, wrapping.
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (stage_valid[LAST] & bus.out_ready_i) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end
        if (stage_valid[LAST] & !bus.out_ready_i) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers; cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops_o   = perf_ops_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_pipe_elastic.sv
// Directed self-checking bench for alu_pipe_elastic (DWIDTH=32, STAGES=3, TAG_W=4).
module tb_alu_pipe_elastic;
    import alu_pipe_elastic_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

`ifdef ALU_PIPE_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;
`endif

    alu_pipe_elastic_if #(.DWIDTH(32), .TAG_W(4)) bus ();

    alu_pipe_elastic #(.DWIDTH(32), .STAGES(3), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_PIPE_PERF_EN
        ,
        .perf_ops_o   (perf_ops),
        .perf_stall_o (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU vectors: sel, op1, op2 -> res, zero, neg
    logic [1:0]  v_sel  [7] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00};
    logic [31:0] v_a    [7] = '{32'd3, 32'd9, 32'hF0, 32'hF0, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF};
    logic [31:0] v_b    [7] = '{32'd5, 32'd9, 32'h0F, 32'h0F, 32'd1, 32'd1, 32'd1};
    logic [31:0] v_res  [7] = '{32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFF, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000};
    logic        v_zero [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        v_neg  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] t);
        bus.sel_i = sel;
        bus.op1_i = a;
        bus.op2_i = b;
        bus.tag_i = t;
    endtask

    // Push one op into an empty pipe with out_ready high and capture its result.
    task automatic do_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, output logic [31:0] r, output logic z,
                         output logic n, output logic [3:0] tg, output bit timeout);
        bus.out_ready_i = 1'b1;
        set_op(sel, a, b, t);
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        timeout = 1'b1;
        r = '0; z = 1'b0; n = 1'b0; tg = '0;
        for (int k = 0; k < 10; k++) begin
            if (bus.out_valid_o) begin
                r = bus.res_o; z = bus.zero_o; n = bus.neg_o; tg = bus.tag_o;
                timeout = 1'b0;
                break;
            end
            tick();
        end
        if (!timeout) tick();
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL reset_valid: got %0b exp 0", bus.out_valid_o); else passes++;
        checks++; if (bus.res_o !== 32'd0) $display("FAIL reset_res: got %0h exp 0", bus.res_o); else passes++;
        checks++; if (bus.zero_o !== 1'b0) $display("FAIL reset_zero: got %0b exp 0", bus.zero_o); else passes++;
        checks++; if (bus.neg_o !== 1'b0) $display("FAIL reset_neg: got %0b exp 0", bus.neg_o); else passes++;
        checks++; if (bus.tag_o !== 4'd0) $display("FAIL reset_tag: got %0h exp 0", bus.tag_o); else passes++;
        checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL reset_in_ready: got %0b exp 1", bus.in_ready_o); else passes++;
        rst = 1'b0;
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL post_reset_valid: got %0b exp 0", bus.out_valid_o); else passes++;
    endtask

    task automatic test_single_op();
        bus.out_ready_i = 1'b1;
        set_op(ALU_ADD, 32'd5, 32'd7, 4'd3);
        bus.in_valid_i = 1'b1;
        #1;
        checks++; if (bus.in_ready_o !== 1'b1) $display("FAIL single_in_ready: got %0b exp 1", bus.in_ready_o); else passes++;
        tick();
        bus.in_valid_i = 1'b0;
        checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL single_lat0: got %0b exp 0", bus.out_valid_o); else passes++;
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL single_lat1: got %0b exp 0", bus.out_valid_o); else passes++;
        tick();
        checks++; if (bus.out_valid_o !== 1'b1) $display("FAIL single_lat2: got %0b exp 1", bus.out_valid_o); else passes++;
        checks++; if (bus.res_o !== 32'd12) $display("FAIL single_res: got %0h exp c", bus.res_o); else passes++;
        checks++; if (bus.zero_o !== 1'b0) $display("FAIL single_zero: got %0b exp 0", bus.zero_o); else passes++;
        checks++; if (bus.neg_o !== 1'b0) $display("FAIL single_neg: got %0b exp 0", bus.neg_o); else passes++;
        checks++; if (bus.tag_o !== 4'd3) $display("FAIL single_tag: got %0h exp 3", bus.tag_o); else passes++;
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL single_pop: got %0b exp 0", bus.out_valid_o); else passes++;
    endtask

    task automatic test_alu_ops();
        logic [31:0] r; logic z; logic n; logic [3:0] tg; bit to;
        for (int i = 0; i < 7; i++) begin
            do_op(v_sel[i], v_a[i], v_b[i], 4'(i + 1), r, z, n, tg, to);
            checks++; if (to !== 1'b0) $display("FAIL alu%0d_timeout: got no result exp result", i); else passes++;
            checks++; if (r !== v_res[i]) $display("FAIL alu%0d_res: got %0h exp %0h", i, r, v_res[i]); else passes++;
            checks++; if (z !== v_zero[i]) $display("FAIL alu%0d_zero: got %0b exp %0b", i, z, v_zero[i]); else passes++;
            checks++; if (n !== v_neg[i]) $display("FAIL alu%0d_neg: got %0b exp %0b", i, n, v_neg[i]); else passes++;
            checks++; if (tg !== 4'(i + 1)) $display("FAIL alu%0d_tag: got %0h exp %0h", i, tg, 4'(i + 1)); else passes++;
        end
    endtask

    task automatic test_stream();
        int sent = 0, got = 0, prev_c = 0;
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 40 && got < 10; c++) begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                checks++; if (bus.res_o !== 32'(got * 7 + 100)) $display("FAIL stream%0d_res: got %0h exp %0h", got, bus.res_o, 32'(got * 7 + 100)); else passes++;
                checks++; if (bus.tag_o !== 4'(got)) $display("FAIL stream%0d_tag: got %0h exp %0h", got, bus.tag_o, 4'(got)); else passes++;
                if (got > 0) begin
                    checks++; if (c !== prev_c + 1) $display("FAIL stream%0d_gap: got cycle %0d exp %0d", got, c, prev_c + 1); else passes++;
                end
                prev_c = c;
                got++;
            end
            if (sent < 10) begin
                set_op(ALU_ADD, 32'(sent * 7), 32'd100, 4'(sent));
                bus.in_valid_i = 1'b1;
            end else begin
                bus.in_valid_i = 1'b0;
            end
            #1;
            if (bus.in_valid_i && bus.in_ready_o) sent++;
            tick();
        end
        bus.in_valid_i = 1'b0;
        checks++; if (got !== 10) $display("FAIL stream_count: got %0d exp 10", got); else passes++;
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0;
        bit prev_stall = 1'b0;
        logic [31:0] prev_res = '0;
        logic [3:0] prev_tag = '0;
        bit rdy;
        bus.out_ready_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            set_op(ALU_ADD, 32'(sent), 32'd1000, 4'(sent));
            bus.in_valid_i = 1'b1;
            #1;
            if (bus.in_ready_o) sent++;
            tick();
        end
        checks++; if (sent !== 3) $display("FAIL bp_accepted: got %0d exp 3", sent); else passes++;
        checks++; if (bus.in_ready_o !== 1'b0) $display("FAIL bp_full_ready: got %0b exp 0", bus.in_ready_o); else passes++;
        checks++; if (bus.res_o !== 32'd1000) $display("FAIL bp_head_res: got %0h exp 3e8", bus.res_o); else passes++;
        for (int c = 0; c < 300 && got < 12; c++) begin
            if (prev_stall) begin
                checks++;
                if (bus.out_valid_o !== 1'b1 || bus.res_o !== prev_res || bus.tag_o !== prev_tag)
                    $display("FAIL bp_stable: got v%0b %0h/%0h exp v1 %0h/%0h", bus.out_valid_o, bus.res_o, bus.tag_o, prev_res, prev_tag);
                else passes++;
            end
            rdy = 1'($urandom_range(0, 1));
            bus.out_ready_i = rdy;
            if (sent < 12) begin
                set_op(ALU_ADD, 32'(sent), 32'd1000, 4'(sent));
                bus.in_valid_i = 1'b1;
            end else begin
                bus.in_valid_i = 1'b0;
            end
            #1;
            if (bus.out_valid_o && rdy) begin
                checks++; if (bus.res_o !== 32'(got + 1000)) $display("FAIL bp%0d_res: got %0h exp %0h", got, bus.res_o, 32'(got + 1000)); else passes++;
                checks++; if (bus.tag_o !== 4'(got)) $display("FAIL bp%0d_tag: got %0h exp %0h", got, bus.tag_o, 4'(got)); else passes++;
                got++;
            end
            prev_stall = bus.out_valid_o && !rdy;
            prev_res = bus.res_o;
            prev_tag = bus.tag_o;
            if (bus.in_valid_i && bus.in_ready_o) sent++;
            tick();
        end
        bus.in_valid_i = 1'b0;
        checks++; if (got !== 12) $display("FAIL bp_count: got %0d exp 12", got); else passes++;
        bus.out_ready_i = 1'b1;
        repeat (4) tick();
        checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL bp_no_dup: got %0b exp 0", bus.out_valid_o); else passes++;
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_op(ALU_ADD, 32'(k), 32'd1, 4'(k + 1));
            bus.in_valid_i = 1'b1;
            tick();
        end
        checks++; if (bus.out_valid_o !== 1'b1) $display("FAIL flush_prefill: got %0b exp 1", bus.out_valid_o); else passes++;
        bus.flush_i = 1'b1;
        set_op(ALU_ADD, 32'd50, 32'd50, 4'hE);
        #1;
        checks++; if (bus.in_ready_o !== 1'b0) $display("FAIL flush_full_ready: got %0b exp 0", bus.in_ready_o); else passes++;
        tick();
        bus.flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL flush_clear: got %0b exp 0", bus.out_valid_o); else passes++;
        repeat (6) begin tick(); if (bus.out_valid_o) seen = 1'b1; end
        checks++; if (seen !== 1'b0) $display("FAIL flush_ghost: got %0b exp 0", seen); else passes++;
        // Flush on an empty pipe must refuse the offered op.
        bus.flush_i = 1'b1;
        set_op(ALU_ADD, 32'd1, 32'd1, 4'hD);
        bus.in_valid_i = 1'b1;
        #1;
        checks++; if (bus.in_ready_o !== 1'b0) $display("FAIL flush_empty_ready: got %0b exp 0", bus.in_ready_o); else passes++;
        tick();
        bus.flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        repeat (5) begin tick(); if (bus.out_valid_o) seen = 1'b1; end
        checks++; if (seen !== 1'b0) $display("FAIL flush_input_dropped: got %0b exp 0", seen); else passes++;
        set_op(ALU_ADD, 32'd20, 32'd22, 4'd5);
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL flush_next_lat0: got %0b exp 0", bus.out_valid_o); else passes++;
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL flush_next_lat1: got %0b exp 0", bus.out_valid_o); else passes++;
        tick();
        checks++; if (bus.out_valid_o !== 1'b1) $display("FAIL flush_next_lat2: got %0b exp 1", bus.out_valid_o); else passes++;
        checks++; if (bus.res_o !== 32'd42) $display("FAIL flush_next_res: got %0h exp 2a", bus.res_o); else passes++;
        checks++; if (bus.tag_o !== 4'd5) $display("FAIL flush_next_tag: got %0h exp 5", bus.tag_o); else passes++;
        tick();
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        logic [31:0] r; logic z; logic n; logic [3:0] tg; bit to;
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_op(ALU_ADD, 32'(k), 32'(k), 4'(k));
            bus.in_valid_i = 1'b1;
            tick();
        end
        checks++; if (bus.out_valid_o !== 1'b1) $display("FAIL arst_pre_valid: got %0b exp 1", bus.out_valid_o); else passes++;
        #3 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid_o !== 1'b0) $display("FAIL arst_valid: got %0b exp 0", bus.out_valid_o); else passes++;
        checks++; if (bus.res_o !== 32'd0) $display("FAIL arst_res: got %0h exp 0", bus.res_o); else passes++;
        checks++; if (bus.tag_o !== 4'd0) $display("FAIL arst_tag: got %0h exp 0", bus.tag_o); else passes++;
`ifdef ALU_PIPE_PERF_EN
        checks++; if (perf_ops !== 32'd0) $display("FAIL arst_perf_ops: got %0d exp 0", perf_ops); else passes++;
        checks++; if (perf_stall !== 32'd0) $display("FAIL arst_perf_stall: got %0d exp 0", perf_stall); else passes++;
`endif
        bus.in_valid_i = 1'b0;
        #2 rst = 1'b0;
        repeat (5) begin tick(); if (bus.out_valid_o) seen = 1'b1; end
        checks++; if (seen !== 1'b0) $display("FAIL arst_no_partial: got %0b exp 0", seen); else passes++;
        // One op stalled for three cycles, then popped; then one more unstalled op.
        bus.out_ready_i = 1'b0;
        set_op(ALU_ADD, 32'd1, 32'd2, 4'd9);
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        repeat (2) tick();
        repeat (3) tick();
        checks++; if (bus.out_valid_o !== 1'b1) $display("FAIL arst_stall_valid: got %0b exp 1", bus.out_valid_o); else passes++;
        checks++; if (bus.res_o !== 32'd3) $display("FAIL arst_stall_res: got %0h exp 3", bus.res_o); else passes++;
        bus.out_ready_i = 1'b1;
        tick();
        do_op(ALU_OR, 32'h1, 32'h2, 4'd7, r, z, n, tg, to);
        checks++; if (r !== 32'd3 || to !== 1'b0) $display("FAIL arst_after_res: got %0h exp 3", r); else passes++;
`ifdef ALU_PIPE_PERF_EN
        checks++; if (perf_ops !== 32'd2) $display("FAIL perf_ops: got %0d exp 2", perf_ops); else passes++;
        checks++; if (perf_stall !== 32'd3) $display("FAIL perf_stall: got %0d exp 3", perf_stall); else passes++;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b0;
        set_op(2'b00, 32'd0, 32'd0, 4'd0);
        test_reset();
        test_single_op();
        test_alu_ops();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
